alu_decode_stage: RTL
=====================

// Module: alu_decode_stage
// PURPOSE
//  ID/EX pipeline stage producing the 4-bit OPERATION code and operand controls consumed by the ALU.
//  Accepts one RV32I instruction per valid/ready handshake, decodes it, and registers the result.
//  Sits between the fetch/regfile stage and the ALU execute stage.
//  Supports stall (OUT_READY low) and flush.
// PARAMETERS
//  CNT_W   16  width of the saturating UNSUPPORTED_CNT counter
// PORTS
//  CLK             in   1      clock, rising edge
//  RESET           in   1      synchronous, active-high reset
//  IN_VALID        in   1      INSTR/PC valid
//  IN_READY        out  1      stage can accept this cycle
//  INSTR           in   32     RV32I instruction word
//  PC              in   32     address of INSTR
//  FLUSH           in   1      discard the held entry and block acceptance this cycle
//  OUT_VALID       out  1      decoded entry valid
//  OUT_READY       in   1      execute stage consumes entry
//  OPERATION       out  4      0000 ADD, 0001 AND, 0010 OR, 0011 SLL, 0100 SLT, 0101 SRL, 0110 SUB, 0111 XOR
//  SRC_A_SEL       out  2      00 rs1, 01 PC, 10 zero
//  SRC_B_IMM       out  1      1: B = IMM, 0: B = rs2
//  RS1/RS2/RD      out  5 ea   register indices INSTR[19:15]/[24:20]/[11:7]
//  REG_WRITE       out  1      write RD on retire
//  BRANCH          out  1      branch; the execute stage uses ZERO or RESULT[0]
//  BR_INVERT       out  1      1 for BNE/BGE (take branch when the condition is false)
//  IMM             out  32     sign-extended immediate (see CONFIGURATION)
//  PC_OUT          out  32     registered PC
//  UNSUPPORTED     out  1      entry not decodable to an ALU op
//  UNSUPPORTED_CNT out  CNT_W  saturating count of accepted unsupported instructions
// BEHAVIOUR
//  Reset: OUT_VALID=0, every registered output=0, UNSUPPORTED_CNT=0. Applies mid-transfer and drops the held entry.
//  Handshake:
//   - IN_READY = !FLUSH && (!OUT_VALID || OUT_READY) (combinational).
//   - Accept when IN_VALID && IN_READY.
//   - Latency: 1 cycle, accept at edge N -> OUT_VALID at N+1.
//   - Full throughput when OUT_READY is held high.
//  Stall: while OUT_VALID && !OUT_READY, all outputs hold stable and IN_READY=0.
//  FLUSH: has priority over everything except RESET.
//   - Next cycle OUT_VALID=0.
//   - Nothing is accepted that cycle; other outputs may hold.
//  Output register update:
//   - Accept: load the decoded fields, OUT_VALID=1.
//   - Consume without accept: OUT_VALID=0.
//  Decode table (opcode -> OPERATION, A, B_IMM, REG_WRITE):
//   - 0110011 R-type: f3 000 -> ADD if f7=0000000, SUB if f7=0100000.
//     f3 111 AND, 110 OR, 001 SLL, 010 SLT, 101 SRL, 100 XOR; each requires f7=0.
//     A=rs1, B_IMM=0, REG_WRITE=1.
//   - 0010011 OP-IMM: same f3 map, no SUB. SLLI/SRLI require f7=0. A=rs1, B_IMM=1, REG_WRITE=1.
//   - 0000011 LOAD / 0100011 STORE: ADD, A=rs1, B_IMM=1. REG_WRITE = 1 for LOAD, 0 for STORE.
//   - 0110111 LUI: ADD, A=zero, B_IMM=1, REG_WRITE=1.
//   - 0010111 AUIPC: ADD, A=PC, B_IMM=1, REG_WRITE=1.
//   - 1100011 BRANCH: BEQ/BNE -> SUB; BLT/BGE -> SLT. A=rs1, B_IMM=0, REG_WRITE=0, BRANCH=1.
//  Unsupported: SRA/SRAI, SLTU/SLTIU, BLTU/BGEU, JAL/JALR, SYSTEM, any other opcode or bad f7.
//   - Outputs: UNSUPPORTED=1, OPERATION=0000, REG_WRITE=0, BRANCH=0, OUT_VALID=1 (passed on as a bubble).
//  UNSUPPORTED_CNT increments by 1 per accepted unsupported entry and saturates at 2^CNT_W-1.
//   - A flushed entry is still counted if it was accepted before the flush.
// CONFIGURATION
//  ALUDEC_IMMGEN_EN defined:
//   - IMM is built from the I/S/B/U formats per opcode, sign-extended; U-type = {INSTR[31:12],12'b0}.
//   - B-type IMM feeds only the branch target; SRC_B_IMM=0 for branches.
//  ALUDEC_IMMGEN_EN undefined:
//   - IMM is tied to 0 and the execute stage builds immediates.
//   - Every other output is identical.
// TESTING
//  - Reset, then add x3,x1,x2 (0x002081B3) with OUT_READY=1 ->
//    next cycle OUT_VALID=1, OPERATION=0000, RS1=1, RS2=2, RD=3, REG_WRITE=1, SRC_B_IMM=0.
//  - sub (0x402081B3) -> 0110; addi x5,x0,-1 (0xFFF00293) -> 0000, SRC_B_IMM=1, IMM=0xFFFFFFFF (with _EN).
//  - Back-to-back stream of 8 instructions with OUT_READY=1 -> 8 consecutive valid outputs, no bubbles.
//  - OUT_READY=0 for 3 cycles with an entry held -> IN_READY=0 and outputs stable; on release the next entry follows.
//  - FLUSH while IN_VALID=1 and OUT_VALID=1 -> IN_READY=0 that cycle, OUT_VALID=0 next cycle.
//  - srai (0x4010D093) and jal (0x0000006F) -> UNSUPPORTED=1, REG_WRITE=0, UNSUPPORTED_CNT=2.
//    With CNT_W=2 and 5 unsupported instructions -> UNSUPPORTED_CNT stays at 3.

Source files
------------

// File: rtl/alu_decode_stage.sv
// rtl/alu_decode_stage.sv - RV32I ID/EX stage decoding one instruction into ALU operation and operand controls
// Optional ALUDEC_IMMGEN_EN: build sign-extended I/S/B/U immediates here; otherwise IMM is tied to zero.
module alu_decode_stage #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instr,
   input  logic [31:0]      pc,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       operation,
   output logic [1:0]       src_a_sel,
   output logic             src_b_imm,
   output logic [4:0]       rs1,
   output logic [4:0]       rs2,
   output logic [4:0]       rd,
   output logic             reg_write,
   output logic             branch,
   output logic             br_invert,
   output logic [31:0]      imm,
   output logic [31:0]      pc_out,
   output logic             unsupported,
   output logic [CNT_W-1:0] unsupported_cnt
);

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_AND = 4'b0001;
   localparam logic [3:0] OP_OR  = 4'b0010;
   localparam logic [3:0] OP_SLL = 4'b0011;
   localparam logic [3:0] OP_SLT = 4'b0100;
   localparam logic [3:0] OP_SRL = 4'b0101;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_XOR = 4'b0111;

   localparam logic [1:0] A_RS1  = 2'b00;
   localparam logic [1:0] A_PC   = 2'b01;
   localparam logic [1:0] A_ZERO = 2'b10;

   logic [6:0]  opcode;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic        accept;
   logic [3:0]  f3_op;
   logic        f3_ok;
   logic [3:0]  d_op;
   logic [1:0]  d_a;
   logic        d_bimm;
   logic        d_rw;
   logic        d_br;
   logic        d_inv;
   logic        d_uns;
   logic [31:0] d_imm;

   assign opcode   = instr[6:0];
   assign f3       = instr[14:12];
   assign f7       = instr[31:25];
   assign in_ready = !flush && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   // funct3 map shared by R-type and OP-IMM; 011 (SLTU/SLTIU) has no ALU op here
   always_comb begin
      f3_op = OP_ADD;
      f3_ok = 1'b1;
      case (f3)
         3'b000:  f3_op = OP_ADD;
         3'b001:  f3_op = OP_SLL;
         3'b010:  f3_op = OP_SLT;
         3'b100:  f3_op = OP_XOR;
         3'b101:  f3_op = OP_SRL;
         3'b110:  f3_op = OP_OR;
         3'b111:  f3_op = OP_AND;
         default: f3_ok = 1'b0;
      endcase
   end

   always_comb begin
      d_op   = OP_ADD;
      d_a    = A_RS1;
      d_bimm = 1'b0;
      d_rw   = 1'b0;
      d_br   = 1'b0;
      d_inv  = 1'b0;
      d_uns  = 1'b0;
      case (opcode)
         7'b0110011: begin
            d_rw = 1'b1;
            if (f7 == 7'b0100000 && f3 == 3'b000) d_op = OP_SUB;
            else if (f7 == 7'b0000000 && f3_ok)  d_op = f3_op;
            else                                  d_uns = 1'b1;
         end
         7'b0010011: begin
            d_bimm = 1'b1;
            d_rw   = 1'b1;
            d_op   = f3_op;
            if (!f3_ok || ((f3 == 3'b001 || f3 == 3'b101) && f7 != 7'b0000000)) d_uns = 1'b1;
         end
         7'b0000011: begin
            d_bimm = 1'b1;
            d_rw   = 1'b1;
         end
         7'b0100011: d_bimm = 1'b1;
         7'b0110111: begin
            d_a    = A_ZERO;
            d_bimm = 1'b1;
            d_rw   = 1'b1;
         end
         7'b0010111: begin
            d_a    = A_PC;
            d_bimm = 1'b1;
            d_rw   = 1'b1;
         end
         7'b1100011: begin
            d_br  = 1'b1;
            d_inv = f3[0];
            case (f3)
               3'b000, 3'b001: d_op = OP_SUB;
               3'b100, 3'b101: d_op = OP_SLT;
               default:        d_uns = 1'b1;
            endcase
         end
         default: d_uns = 1'b1;
      endcase
      // unsupported entries travel as harmless bubbles
      if (d_uns) begin
         d_op   = OP_ADD;
         d_a    = A_RS1;
         d_bimm = 1'b0;
         d_rw   = 1'b0;
         d_br   = 1'b0;
         d_inv  = 1'b0;
      end
   end

`ifdef ALUDEC_IMMGEN_EN
   always_comb begin
      d_imm = '0;
      case (opcode)
         7'b0010011, 7'b0000011: d_imm = {{20{instr[31]}}, instr[31:20]};
         7'b0100011:             d_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         7'b1100011:             d_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         7'b0110111, 7'b0010111: d_imm = {instr[31:12], 12'b0};
         default:                d_imm = '0;
      endcase
      if (d_uns) d_imm = '0;
   end
`else
   assign d_imm = '0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid       <= 1'b0;
         operation       <= '0;
         src_a_sel       <= '0;
         src_b_imm       <= 1'b0;
         rs1             <= '0;
         rs2             <= '0;
         rd              <= '0;
         reg_write       <= 1'b0;
         branch          <= 1'b0;
         br_invert       <= 1'b0;
         imm             <= '0;
         pc_out          <= '0;
         unsupported     <= 1'b0;
         unsupported_cnt <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid   <= 1'b1;
         operation   <= d_op;
         src_a_sel   <= d_a;
         src_b_imm   <= d_bimm;
         rs1         <= instr[19:15];
         rs2         <= instr[24:20];
         rd          <= instr[11:7];
         reg_write   <= d_rw;
         branch      <= d_br;
         br_invert   <= d_inv;
         imm         <= d_imm;
         pc_out      <= pc;
         unsupported <= d_uns;
         if (d_uns && unsupported_cnt != {CNT_W{1'b1}})
            unsupported_cnt <= unsupported_cnt + CNT_W'(1);
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
